// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand-issue stage in front of the 32-bit ALU.
// 8x32 register file (r0 hardwired to 0), operand read on accept, and a
// 2-entry skid buffer (OUT + SKID) with valid/ready flow control.
// Undefined opcodes (7, 15) complete the handshake but are dropped and counted.
// Optional macro ALU_ISSUE_BYPASS_EN: forward same-cycle writeback data into
// operands read at accept; when undefined, operands see the pre-write value.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 3,
    parameter int OPC_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic [RA_W-1:0]   in_rs0,
    input  logic [RA_W-1:0]   in_rs1,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_use_imm,
    input  logic              wb_en,
    input  logic [RA_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data0,
    output logic [DATA_W-1:0] data1,
    output logic [OPC_W-1:0]  opcode,
    output logic              illegal_op,
    output logic [CNT_W-1:0]  illegal_cnt
);
    localparam int NREG = 2**RA_W;

    typedef struct packed {
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
        logic [OPC_W-1:0]  opc;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rf [NREG];
    entry_t            out_q, skid_q, new_e;
    logic [DATA_W-1:0] rd0, rd1;
    logic              legal, acc, enq, pop;
    logic              load_out, load_skid, shift_skid;

    assign legal = (in_opcode != OPC_W'(7)) && (in_opcode != OPC_W'(15));
    assign acc   = in_valid & in_ready;
    assign enq   = acc & legal;
    assign out_valid = (state_q != EMPTY);
    assign pop   = out_valid & out_ready;

    // Register read; r0 is always zero, optional same-cycle writeback bypass
    always_comb begin
        rd0 = (in_rs0 == '0) ? '0 : rf[in_rs0];
        rd1 = (in_rs1 == '0) ? '0 : rf[in_rs1];
`ifdef ALU_ISSUE_BYPASS_EN
        if (wb_en && wb_addr != '0 && wb_addr == in_rs0) rd0 = wb_data;
        if (wb_en && wb_addr != '0 && wb_addr == in_rs1) rd1 = wb_data;
`endif
        new_e.d0  = rd0;
        new_e.d1  = in_use_imm ? in_imm : rd1;
        new_e.opc = in_opcode;
    end

    // Skid-buffer next state and load controls; illegal ops count as no accept
    always_comb begin
        state_d    = state_q;
        load_out   = 1'b0;
        load_skid  = 1'b0;
        shift_skid = 1'b0;
        case (state_q)
            EMPTY: if (enq) begin
                state_d  = HALF;
                load_out = 1'b1;
            end
            HALF: begin
                if (enq && !pop) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (pop && !enq) begin
                    state_d = EMPTY;
                end else if (enq && pop) begin
                    load_out = 1'b1;
                end
            end
            FULL: if (pop) begin
                state_d    = HALF;
                shift_skid = 1'b1;
            end
            default: state_d = EMPTY;
        endcase
    end

    // State, registered in_ready, and operand buffers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= EMPTY;
            in_ready <= 1'b1;
            out_q    <= '0;
            skid_q   <= '0;
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d != FULL);
            if (load_out)        out_q  <= new_e;
            else if (shift_skid) out_q  <= skid_q;
            if (load_skid)       skid_q <= new_e;
        end
    end

    assign data0  = out_q.d0;
    assign data1  = out_q.d1;
    assign opcode = out_q.opc;

    // Register file write port; writes to r0 are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Sticky illegal flag and saturating illegal-opcode counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_op  <= 1'b0;
            illegal_cnt <= '0;
        end else if (acc && !legal) begin
            illegal_op <= 1'b1;
            if (illegal_cnt != '1) illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_use_imm, wb_en, out_valid, out_ready, illegal_op;
    logic [3:0]  in_opcode, opcode;
    logic [2:0]  in_rs0, in_rs1, wb_addr;
    logic [31:0] in_imm, wb_data, data0, data1;
    logic [7:0]  illegal_cnt;

    int npass = 0;
    int ntotal = 0;

    alu_issue_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rs0(in_rs0), .in_rs1(in_rs1), .in_imm(in_imm), .in_use_imm(in_use_imm),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .data0(data0), .data1(data1), .opcode(opcode),
        .illegal_op(illegal_op), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // advance one clock; sample point is 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [2:0] rs0, input logic [2:0] rs1,
                         input logic use_imm, input logic [31:0] imm);
        in_valid = 1'b1; in_opcode = op; in_rs0 = rs0; in_rs1 = rs1;
        in_use_imm = use_imm; in_imm = imm;
    endtask

    initial begin
        logic [31:0] exp_byp;
        reset = 1'b1; in_valid = 0; in_opcode = 0; in_rs0 = 0; in_rs1 = 0; in_imm = 0;
        in_use_imm = 0; wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 0;
        #12;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_data0", data0, 32'h0);
        chk("reset_illegal_op", 32'(illegal_op), 32'd0);
        chk("reset_illegal_cnt", 32'(illegal_cnt), 32'd0);
        @(negedge clk); reset = 1'b0;
        tick();

        // 1: basic issue
        wb_en = 1; wb_addr = 3; wb_data = 32'h10; tick();
        wb_addr = 5; wb_data = 32'h3; tick();
        wb_en = 0;
        out_ready = 1;
        issue(4'd0, 3'd3, 3'd5, 1'b0, 32'h0); tick();
        in_valid = 0;
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_data0", data0, 32'h10);
        chk("t1_data1", data1, 32'h3);
        chk("t1_opcode", 32'(opcode), 32'd0);
        tick();
        chk("t1_drained", 32'(out_valid), 32'd0);

        // 2: back-pressure, skid fill and ordered drain
        out_ready = 0;
        issue(4'd1, 3'd3, 3'd0, 1'b1, 32'hA1); tick();
        chk("t2_ready_after_1st", 32'(in_ready), 32'd1);
        issue(4'd2, 3'd3, 3'd0, 1'b1, 32'hB2); tick();
        chk("t2_ready_after_2nd", 32'(in_ready), 32'd0);
        issue(4'd3, 3'd3, 3'd0, 1'b1, 32'hC3); tick();
        chk("t2_stall_ready", 32'(in_ready), 32'd0);
        chk("t2_hold_data1", data1, 32'hA1);
        chk("t2_hold_opcode", 32'(opcode), 32'd1);
        out_ready = 1; tick();
        chk("t2_second_data1", data1, 32'hB2);
        chk("t2_second_opcode", 32'(opcode), 32'd2);
        chk("t2_ready_reopen", 32'(in_ready), 32'd1);
        tick();
        in_valid = 0;
        chk("t2_third_data1", data1, 32'hC3);
        chk("t2_third_opcode", 32'(opcode), 32'd3);
        chk("t2_third_data0", data0, 32'h10);
        tick();
        chk("t2_empty", 32'(out_valid), 32'd0);

        // 3: undefined opcodes and saturation
        issue(4'd7, 3'd3, 3'd5, 1'b0, 32'h0); tick();
        chk("t3_op7_no_valid", 32'(out_valid), 32'd0);
        chk("t3_op7_ready", 32'(in_ready), 32'd1);
        issue(4'd15, 3'd3, 3'd5, 1'b0, 32'h0); tick();
        in_valid = 0;
        chk("t3_op15_no_valid", 32'(out_valid), 32'd0);
        chk("t3_illegal_op", 32'(illegal_op), 32'd1);
        chk("t3_illegal_cnt2", 32'(illegal_cnt), 32'd2);
        issue(4'd7, 3'd0, 3'd0, 1'b0, 32'h0);
        for (int i = 0; i < 252; i++) tick();
        chk("t3_cnt254", 32'(illegal_cnt), 32'd254);
        tick();
        chk("t3_cnt255", 32'(illegal_cnt), 32'd255);
        for (int i = 0; i < 47; i++) tick();
        in_valid = 0;
        chk("t3_cnt_saturated", 32'(illegal_cnt), 32'd255);
        chk("t3_no_valid_after_300", 32'(out_valid), 32'd0);

        // 4: write and read of the same register in one cycle
`ifdef ALU_ISSUE_BYPASS_EN
        exp_byp = 32'hDEAD_BEEF;
`else
        exp_byp = 32'h0;
`endif
        wb_en = 1; wb_addr = 2; wb_data = 32'hDEAD_BEEF;
        issue(4'd5, 3'd2, 3'd0, 1'b1, 32'h0); tick();
        wb_en = 0; in_valid = 0;
        chk("t4_same_cycle_data0", data0, exp_byp);
        tick();
        issue(4'd5, 3'd2, 3'd0, 1'b1, 32'h0); tick();
        in_valid = 0;
        chk("t4_after_write_data0", data0, 32'hDEAD_BEEF);
        tick();

        // 5: r0 ignores writes, immediate operand
        wb_en = 1; wb_addr = 0; wb_data = 32'hFFFF_FFFF; tick();
        wb_en = 0;
        issue(4'd4, 3'd0, 3'd0, 1'b1, 32'h7); tick();
        in_valid = 0;
        chk("t5_r0_data0", data0, 32'h0);
        chk("t5_imm_data1", data1, 32'h7);
        tick();

        // 6: reset while FULL
        out_ready = 0;
        issue(4'd1, 3'd3, 3'd5, 1'b0, 32'h0); tick();
        issue(4'd2, 3'd3, 3'd5, 1'b0, 32'h0); tick();
        in_valid = 0;
        chk("t6_full_ready", 32'(in_ready), 32'd0);
        reset = 1'b1; #1;
        chk("t6_async_out_valid", 32'(out_valid), 32'd0);
        chk("t6_async_illegal_cnt", 32'(illegal_cnt), 32'd0);
        @(negedge clk); reset = 1'b0;
        tick();
        chk("t6_ready_after_release", 32'(in_ready), 32'd1);
        chk("t6_valid_after_release", 32'(out_valid), 32'd0);
        out_ready = 1;
        issue(4'd6, 3'd3, 3'd5, 1'b0, 32'h0); tick();
        issue(4'd6, 3'd2, 3'd0, 1'b0, 32'h0);
        chk("t6_r3_cleared", data0, 32'h0);
        chk("t6_r5_cleared", data1, 32'h0);
        tick();
        in_valid = 0;
        chk("t6_r2_cleared", data0, 32'h0);
        chk("t6_opcode", 32'(opcode), 32'd6);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
